// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl
//   Interrupt controller with a fixed-priority encoder (lowest index wins).
//   It captures the interrupt lines into pending bits and gates them with an
//   enable mask. It then presents a registered ID to the core through a
//   req/ack handshake and blocks further requests until end-of-service.
//
// Parameters
//   NUM_IRQ    number of interrupt lines (1..2**ID_W)
//   ID_W       width of the interrupt ID
//   EDGE_MASK  bit i = 1: line i is rising-edge triggered (sticky pending)
//              bit i = 0: line i is level triggered (pending = registered line)
//
// Ports
//   clk       clock, rising edge
//   res_n     asynchronous active-low reset
//   irq_in    raw interrupt lines, synchronous to clk
//   irq_en    per-line enable mask (gates selection only)
//   irq_req   interrupt request to the core
//   irq_id    ID of the requested interrupt, valid while irq_req = 1
//   irq_ack   core accepts the request
//   irq_done  core finished the handler
//   pending   pending bits, for debug/CSR readback
//   busy      1 while a handler is in service
// ----------------------------------------------------------------------------
module irq_ctrl #(
    parameter int unsigned          NUM_IRQ   = 32,
    parameter int unsigned          ID_W      = 5,
    parameter logic [NUM_IRQ-1:0]   EDGE_MASK = '1
) (
    input  logic               clk,
    input  logic               res_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_en,
    output logic               irq_req,
    output logic [ID_W-1:0]    irq_id,
    input  logic               irq_ack,
    input  logic               irq_done,
    output logic [NUM_IRQ-1:0] pending,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   irq_prev_q;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [ID_W-1:0]      irq_id_q, irq_id_d;

    logic [NUM_IRQ-1:0]   set_edge;
    logic [NUM_IRQ-1:0]   ack_clr;
    logic [NUM_IRQ-1:0]   cand;
    logic                 sel_found;
    logic [ID_W-1:0]      sel_id;

    // Pending update. For edge lines the set term is OR-ed in after the
    // clear term, so an edge that coincides with its own ack is kept.
    always_comb begin
        set_edge = irq_in & ~irq_prev_q;
        ack_clr  = '0;
        if (state_q == S_REQ && irq_ack) begin
            for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                ack_clr[i] = (irq_id_q == ID_W'(i));
            end
        end
        pending_d = (EDGE_MASK & ((pending_q & ~ack_clr) | set_edge))
                  | (~EDGE_MASK & irq_in);
    end

    // Fixed-priority encoder: the first set candidate from index 0 upward
    always_comb begin
        cand      = pending_q & irq_en;
        sel_found = 1'b0;
        sel_id    = '0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (cand[i] && !sel_found) begin
                sel_found = 1'b1;
                sel_id    = ID_W'(i);
            end
        end
    end

    // Next-state logic. irq_id only loads when a request is issued, so it
    // stays stable through REQ and keeps its last value afterwards.
    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        unique case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    irq_id_d = sel_id;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    state_d = S_SERVICE;
                end
            end
            S_SERVICE: begin
                if (irq_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q    <= S_IDLE;
            irq_prev_q <= '0;
            pending_q  <= '0;
            irq_id_q   <= '0;
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_in;
            pending_q  <= pending_d;
            irq_id_q   <= irq_id_d;
        end
    end

    // Request and busy are decodes of the registered state
    assign irq_req = (state_q == S_REQ);
    assign busy    = (state_q == S_SERVICE);
    assign irq_id  = irq_id_q;
    assign pending = pending_q;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller; the successor to the single-ID interrupt latch in the core front-end.
- Captures NUM_IRQ interrupt lines into pending bits, applies an enable mask and selects the highest-priority source with a fixed-priority encoder.
- Presents a registered interrupt ID to the core with a req/ack handshake, then blocks further requests until the core signals end-of-service.

Parameters:
- NUM_IRQ, 32, number of interrupt lines, 1..2**ID_W.
- ID_W, 5, width of the interrupt ID.
- EDGE_MASK, all ones (NUM_IRQ bits), bit i=1: line i is rising-edge triggered; bit i=0: line i is level triggered.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res_n  in  1  asynchronous active-low reset.
- irq_in  in  NUM_IRQ  raw interrupt lines, synchronous to clk.
- irq_en  in  NUM_IRQ  per-line enable mask.
- irq_req  out  1  interrupt request to the core.
- irq_id  out  ID_W  ID of the requested interrupt; valid while irq_req=1.
- irq_ack  in  1  core accepts the request.
- irq_done  in  1  core finished the handler (mret).
- pending  out  NUM_IRQ  pending bits, for debug/CSR readback.
- busy  out  1  1 while in the SERVICE state.

Behaviour:
- Reset (res_n=0, asynchronous): pending=0, irq_req=0, irq_id=0, busy=0, irq_in history register=0, state=IDLE.
- Edge lines: pending[i] sets when irq_in[i]=1 and the previous-cycle sample=0. The flag is sticky until cleared by an acknowledge.
- Level lines: pending[i] = registered irq_in[i] (one-cycle latency). No stickiness; the ack has no effect on these bits.
- Pending bits capture regardless of irq_en. The mask only gates selection.
- Selection: candidate = pending & irq_en. The lowest index has the highest priority. The selected ID is zero-extended to ID_W.
- FSM states:
  - IDLE: if candidate != 0, register irq_id = selected index, set irq_req=1, go to REQ. The request appears 1 cycle after the pending bit is set (2 cycles after an edge on irq_in).
  - REQ: irq_req and irq_id are held stable and do not change even if a higher-priority line becomes pending. On irq_ack=1: irq_req=0, clear pending[irq_id] if that line is edge-type, set busy=1, go to SERVICE.
  - SERVICE: no new requests. New edges keep accumulating in pending. On irq_done=1: busy=0, go to IDLE. The next request can be issued in the cycle after IDLE is re-entered.
- Simultaneous events:
  - A set and a clear of the same edge pending bit in the same cycle: the set wins, and a new edge is not lost.
  - irq_done in IDLE or REQ is ignored. irq_ack outside REQ is ignored.
- Disabling a line while in REQ does not retract the request; the core must still ack it.
- irq_id holds its last value after the ack until the next request.
- Reset asserted mid-operation returns everything to the reset values immediately, with no pending carry-over.

Test Plan:
1. Reset release, then pulse irq_in[5] for 1 cycle with irq_en=all ones -> irq_req=1 and irq_id=5 two cycles after the edge. Ack -> pending[5]=0, busy=1. irq_done -> busy=0, and irq_req stays 0.
2. Edge on irq_in[3] and irq_in[9] in the same cycle -> ID 3 is served first. After irq_done, irq_req returns with irq_id=9 within 2 cycles.
3. irq_in[7] pending while irq_en[7]=0 -> no request. Set irq_en[7]=1 -> request with irq_id=7 one cycle later.
4. In REQ with irq_id=10, an edge arrives on line 2 -> irq_id stays 10 until ack. Line 2 is requested after irq_done.
5. Level line 4 (EDGE_MASK[4]=0) held high through ack and done -> it is re-requested immediately after irq_done. Drop it before done -> no re-request.
6. Assert res_n=0 during SERVICE with pending lines 1 and 6 set -> all outputs 0 asynchronously. After release with no new inputs, no request is issued.
